// File: rtl/pipe_mem_pkg.sv
// Shared defaults, FSM encoding and a width helper for the pipeline memory arbiter.
package pipe_mem_pkg;

  localparam int ADDR_W_DEF      = 32;
  localparam int DATA_W_DEF      = 32;
  localparam int TIMEOUT_CYC_DEF = 255;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_DONE  = 2'd3
  } arb_state_e;

  // Bits needed to hold a counter value in 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready and raises a sticky timeout flag.
module mem_wait_timer
  import pipe_mem_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic wait_cyc,
  output logic timeout_err
);

  localparam int CNT_W = cnt_width(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  // Counter saturates at the limit so a long stall never wraps back below it.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (wait_cyc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
    err_d = err_q | (cnt_d == CNT_MAX);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;

endmodule

// File: rtl/pipe_mem_arbiter.sv
// Arbitrates a single-port memory between instruction fetch and the MEM stage,
// buffering one instruction and generating the pipeline stall controls.
module pipe_mem_arbiter
  import pipe_mem_pkg::*;
#(
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_read,
  input  logic              dm_write,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              pipe_freeze,
  output logic              timeout_err
);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic              if_valid_q, if_valid_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
  logic              dm_valid_q, dm_valid_d;
  logic              drop_q, drop_d;

  logic dm_req;
  logic consume;
  logic grant;
  logic waiting;

  assign dm_req      = dm_read | dm_write;
  assign pipe_freeze = dm_req & ~dm_valid_q;
  assign consume     = if_valid_q & ~pipe_freeze & ~if_flush;
  assign waiting     = ((state_q == ST_FETCH) || (state_q == ST_DATA)) & ~mem_ready;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    if_rdata_d  = if_rdata_q;
    if_valid_d  = if_valid_q;
    dm_rdata_d  = dm_rdata_q;
    dm_valid_d  = 1'b0;
    drop_d      = drop_q;
    grant       = 1'b0;

    if (consume || if_flush) begin
      if_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (dm_req) begin
          grant       = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = dm_write;
          mem_addr_d  = dm_addr;
          mem_wdata_d = dm_wdata;
          state_d     = ST_DATA;
        end else if (if_req && !if_valid_q && !if_flush) begin
          grant       = 1'b1;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          drop_d      = 1'b0;
          state_d     = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          drop_d    = 1'b0;
          state_d   = ST_IDLE;
          // A redirect seen at any point of the fetch makes the word stale.
          if (!drop_q && !if_flush) begin
            if_rdata_d = mem_rdata;
            if_valid_d = 1'b1;
          end
        end else if (if_flush) begin
          drop_d = 1'b1;
        end
      end
      ST_DATA: begin
        if (mem_ready) begin
          mem_req_d  = 1'b0;
          mem_we_d   = 1'b0;
          dm_valid_d = 1'b1;
          state_d    = ST_DONE;
          if (!mem_we_q) begin
            dm_rdata_d = mem_rdata;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_rdata_q  <= '0;
      dm_valid_q  <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if_rdata_q  <= if_rdata_d;
      if_valid_q  <= if_valid_d;
      dm_rdata_q  <= dm_rdata_d;
      dm_valid_q  <= dm_valid_d;
      drop_q      <= drop_d;
    end
  end

  mem_wait_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_wait_timer (
    .clk        (clk),
    .rst        (rst),
    .clear      (grant),
    .wait_cyc   (waiting),
    .timeout_err(timeout_err)
  );

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign if_rdata   = if_rdata_q;
  assign if_valid   = if_valid_q;
  assign dm_rdata   = dm_rdata_q;
  assign dm_valid   = dm_valid_q;
  assign pc_write   = consume;
  assign ifid_write = consume;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Randomised bench for pipe_mem_arbiter: a memory responder plus a reference
// model of the buffer, stall, completion and timeout rules.
module tb_pipe_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_flush = 1'b0;
  logic [DW-1:0] if_rdata;
  logic          if_valid;
  logic          dm_read = 1'b0;
  logic          dm_write = 1'b0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic [DW-1:0] dm_rdata;
  logic          dm_valid;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          mem_ready = 1'b0;
  logic          pc_write;
  logic          ifid_write;
  logic          pipe_freeze;
  logic          timeout_err;

  always #5 clk = ~clk;

  pipe_mem_arbiter #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_flush   (if_flush),
    .if_rdata   (if_rdata),
    .if_valid   (if_valid),
    .dm_read    (dm_read),
    .dm_write   (dm_write),
    .dm_addr    (dm_addr),
    .dm_wdata   (dm_wdata),
    .dm_rdata   (dm_rdata),
    .dm_valid   (dm_valid),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .ifid_write (ifid_write),
    .pipe_freeze(pipe_freeze),
    .timeout_err(timeout_err)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int txn_id  = 0;

  // phys is what the responder serves; ref_mem is what the bench believes
  // memory should hold, updated only from the bench's own stimulus.
  logic [DW-1:0] phys    [256];
  logic [DW-1:0] ref_mem [256];

  bit            busy      = 1'b0;
  bit            exp_ifv   = 1'b0;
  bit            exp_dmv   = 1'b0;
  bit            exp_err   = 1'b0;
  bit            done_next = 1'b0;
  bit            fill_next = 1'b0;
  logic [DW-1:0] exp_ifd   = '0;
  logic [DW-1:0] fill_data = '0;
  int            wait_cnt  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock: combinational checks before the edge, registered checks after.
  task automatic tick();
    bit frz;
    bit pcw;
    #1;
    frz = (dm_read || dm_write) && !exp_dmv;
    pcw = exp_ifv && !frz && !if_flush;
    check("pipe_freeze", pipe_freeze, frz);
    check("pc_write", pc_write, pcw);
    check("ifid_write", ifid_write, pcw);
    if (busy && !mem_ready) wait_cnt++;
    if (pcw || if_flush) exp_ifv = 1'b0;
    @(posedge clk);
    #1;
    exp_dmv   = done_next;
    done_next = 1'b0;
    if (fill_next) begin
      exp_ifv   = 1'b1;
      exp_ifd   = fill_data;
      fill_next = 1'b0;
    end
    if (wait_cnt >= TO) exp_err = 1'b1;
    check("dm_valid", dm_valid, exp_dmv);
    check("if_valid", if_valid, exp_ifv);
    check("timeout_err", timeout_err, exp_err);
    if (exp_ifv) check("if_rdata", if_rdata, exp_ifd);
  endtask

  task automatic check_hold(input string tag, input logic [AW-1:0] addr, input bit we,
                            input logic [DW-1:0] wdata);
    check({tag, "_req"}, mem_req, 1'b1);
    check({tag, "_addr"}, mem_addr, addr);
    check({tag, "_we"}, mem_we, we);
    if (we) check({tag, "_wdata"}, mem_wdata, wdata);
  endtask

  task automatic do_reset();
    #3;
    rst = 1'b0;
    #1;
    check("rst_mem_req", mem_req, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, '0);
    check("rst_mem_wdata", mem_wdata, '0);
    check("rst_if_valid", if_valid, 1'b0);
    check("rst_if_rdata", if_rdata, '0);
    check("rst_dm_valid", dm_valid, 1'b0);
    check("rst_dm_rdata", dm_rdata, '0);
    check("rst_timeout", timeout_err, 1'b0);
    if_req = 1'b0; if_flush = 1'b0; dm_read = 1'b0; dm_write = 1'b0; mem_ready = 1'b0;
    busy = 1'b0; exp_ifv = 1'b0; exp_dmv = 1'b0; exp_err = 1'b0;
    done_next = 1'b0; fill_next = 1'b0; wait_cnt = 0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    $display("[TB] reset applied and released at %0t", $time);
  endtask

  task automatic do_data(input bit rd, input bit wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input int lat);
    logic [7:0] idx;
    idx = addr[9:2];
    dm_read = rd; dm_write = wr; dm_addr = addr; dm_wdata = wdata; mem_ready = 1'b0;
    wait_cnt = 0;
    tick();
    busy = 1'b1;
    check_hold("dgrant", addr, wr, wdata);
    for (int i = 0; i < lat; i++) begin
      tick();
      check_hold("dhold", addr, wr, wdata);
    end
    mem_ready = 1'b1;
    if (mem_we) phys[mem_addr[9:2]] = mem_wdata;
    mem_rdata = phys[mem_addr[9:2]];
    done_next = 1'b1;
    tick();
    busy = 1'b0;
    check("d_req_drop", mem_req, 1'b0);
    if (wr) ref_mem[idx] = wdata;
    else    check("dm_rdata", dm_rdata, ref_mem[idx]);
    dm_read = 1'b0; dm_write = 1'b0;
    mem_ready = 1'($urandom_range(0, 1));
    mem_rdata = $urandom;
    tick();
    mem_ready = 1'b0;
    txn_id++;
    $display("[TB] txn %0d data rd=%0b wr=%0b addr=%h wdata=%h lat=%0d dm_rdata=%h",
             txn_id, rd, wr, addr, wdata, lat, dm_rdata);
  endtask

  task automatic do_fetch(input logic [AW-1:0] addr, input int lat, input int flush_at);
    logic [7:0] idx;
    bit flushed;
    idx = addr[9:2];
    flushed = (flush_at >= 0);
    if (exp_ifv) begin
      if_req = 1'b0;
      tick();
    end
    if_req = 1'b1; if_addr = addr; wait_cnt = 0;
    tick();
    busy = 1'b1;
    check_hold("fgrant", addr, 1'b0, '0);
    for (int i = 0; i < lat; i++) begin
      if (i == flush_at) begin
        if_flush = 1'b1;
        if_req = 1'b0;
      end
      tick();
      if_flush = 1'b0;
      check_hold("fhold", addr, 1'b0, '0);
    end
    mem_ready = 1'b1;
    mem_rdata = phys[mem_addr[9:2]];
    if (!flushed) begin
      fill_next = 1'b1;
      fill_data = ref_mem[idx];
    end
    tick();
    busy = 1'b0; mem_ready = 1'b0; if_req = 1'b0;
    check("f_req_drop", mem_req, 1'b0);
    if (flushed) tick();
    txn_id++;
    $display("[TB] txn %0d fetch addr=%h lat=%0d flush_at=%0d if_valid=%0b if_rdata=%h",
             txn_id, addr, lat, flush_at, if_valid, if_rdata);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int lat;
    logic [AW-1:0] addr;
    for (int i = 0; i < 256; i++) begin
      phys[i]    = $urandom;
      ref_mem[i] = phys[i];
    end
    phys[16]    = 32'h8C22_0004;
    ref_mem[16] = 32'h8C22_0004;

    @(posedge clk);
    #1;
    do_reset();

    // Single fetch, minimum latency.
    do_fetch(32'h40, 0, -1);
    check("fetch_0x40_word", if_rdata, 32'h8C22_0004);
    tick();

    // Store with two stall cycles, then load it back.
    do_data(1'b0, 1'b1, 32'h20, 32'hDEAD_BEEF, 2);
    do_data(1'b1, 1'b0, 32'h20, '0, 0);
    check("readback_0x20", dm_rdata, 32'hDEAD_BEEF);

    // Load and fetch requested together: load must go first.
    if_req = 1'b1;
    if_addr = 32'h200;
    do_data(1'b1, 1'b0, 32'h100, '0, 1);
    do_fetch(32'h200, 0, -1);

    // Buffered instruction held while a load freezes the pipe.
    do_fetch(32'h80, 1, -1);
    do_data(1'b1, 1'b0, 32'h84, '0, 1);

    // Redirect during the fetch: returned word is discarded.
    do_fetch(32'h44, 1, 0);

    // Read and write high together behave as a write.
    do_data(1'b1, 1'b1, 32'h60, 32'h1234_5678, 0);
    do_data(1'b1, 1'b0, 32'h60, '0, 0);

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 4);
      addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      case (kind)
        0: do_data(1'b1, 1'b0, addr, '0, $urandom_range(0, 3));
        1: do_data(1'b0, 1'b1, addr, $urandom, $urandom_range(0, 3));
        2: do_data(1'b1, 1'b1, addr, $urandom, $urandom_range(0, 3));
        3: do_fetch(addr, $urandom_range(0, 3), -1);
        default: begin
          lat = $urandom_range(1, 3);
          do_fetch(addr, lat, $urandom_range(0, lat - 1));
        end
      endcase
    end

    // Stall beyond the timeout limit; flag is sticky until reset.
    do_data(1'b1, 1'b0, 32'h30, '0, 6);
    check("timeout_set", timeout_err, 1'b1);
    do_fetch(32'h34, 0, -1);
    tick();
    check("timeout_sticky", timeout_err, 1'b1);
    do_reset();

    // Reset in the middle of a load: access abandoned, no completion later.
    dm_read = 1'b1;
    dm_addr = 32'h100;
    wait_cnt = 0;
    tick();
    busy = 1'b1;
    check("midrst_req_before", mem_req, 1'b1);
    do_reset();
    mem_ready = 1'b1;
    mem_rdata = $urandom;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("midrst_req_after", mem_req, 1'b0);
    end
    mem_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
